// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V pipeline control unit.
package riscv_pkg;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StRedirect,
        StIntrWait
    } pipe_state_e;

    localparam int unsigned DefaultTimeoutCycles = 256;

endpackage

// File: rtl/riscv_pu_pipe_ctrl_if.sv
// Stall/flush handshake bundle between the pipeline datapath and its controller.
interface riscv_pu_pipe_ctrl_if;

    logic       enable;
    logic       i_ex_read;
    logic [4:0] i_ex_rd_addr;
    logic [4:0] i_id_rs1_addr;
    logic [4:0] i_id_rs2_addr;
    logic       i_jump_branch;
    logic       i_mem_req;
    logic       i_mem_done;
    logic       i_interr_req;

    logic       o_stall_if;
    logic       o_stall_id;
    logic       o_stall_rd_reg;
    logic       o_stall_wr_reg;
    logic       o_stall_ex;
    logic       o_stall_mem;
    logic       o_flush_if;
    logic       o_flush_id;
    logic       o_flush_ex;
    logic       o_interr;
    logic       o_interr_ack;
    logic       o_mem_timeout;

    // Datapath side: raises events, consumes stall/flush controls.
    modport master (
        output enable, i_ex_read, i_ex_rd_addr, i_id_rs1_addr, i_id_rs2_addr,
               i_jump_branch, i_mem_req, i_mem_done, i_interr_req,
        input  o_stall_if, o_stall_id, o_stall_rd_reg, o_stall_wr_reg, o_stall_ex,
               o_stall_mem, o_flush_if, o_flush_id, o_flush_ex, o_interr,
               o_interr_ack, o_mem_timeout
    );

    // Controller side.
    modport slave (
        input  enable, i_ex_read, i_ex_rd_addr, i_id_rs1_addr, i_id_rs2_addr,
               i_jump_branch, i_mem_req, i_mem_done, i_interr_req,
        output o_stall_if, o_stall_id, o_stall_rd_reg, o_stall_wr_reg, o_stall_ex,
               o_stall_mem, o_flush_if, o_flush_id, o_flush_ex, o_interr,
               o_interr_ack, o_mem_timeout
    );

endinterface

// File: rtl/riscv_pu_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds an operand in ID.
module riscv_pu_hazard_detect (
    input  logic       ex_read_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    output logic       hazard_o
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign hazard_o = ex_read_i && (ex_rd_addr_i != 5'd0) &&
                      ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));

endmodule

// File: rtl/riscv_pu_pipe_ctrl.sv
// Pipeline stall/flush controller: memory wait, redirect, interrupt entry and load-use.
// Optional memory-wait watchdog enabled by RISCV_PU_PIPE_CTRL_TIMEOUT_EN.
module riscv_pu_pipe_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic                 clk,
    input  logic                 nreset,
    riscv_pu_pipe_ctrl_if.slave  bus
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    pipe_state_e state_q, state_d;
    logic        load_use;
    logic        wd_expired;

    logic stall_if, stall_id, stall_ex, stall_mem;
    logic flush_if, flush_id, flush_ex;
    logic interr, interr_ack, mem_timeout;

    riscv_pu_hazard_detect u_hazard_detect (
        .ex_read_i     (bus.i_ex_read),
        .ex_rd_addr_i  (bus.i_ex_rd_addr),
        .id_rs1_addr_i (bus.i_id_rs1_addr),
        .id_rs2_addr_i (bus.i_id_rs2_addr),
        .hazard_o      (load_use)
    );

`ifdef RISCV_PU_PIPE_CTRL_TIMEOUT_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;

    assign wd_expired = (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // Held at zero in every other state, so it is clear on each entry to MEM_WAIT.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (bus.enable) begin
            if (state_q == StMemWait) wd_cnt_d = wd_cnt_q + 16'd1;
            else                      wd_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) wd_cnt_q <= 16'd0;
        else         wd_cnt_q <= wd_cnt_d;
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= StRun;
        else         state_q <= state_d;
    end

    // Outputs are Mealy and forced low while in reset or disabled.
    always_comb begin
        state_d     = state_q;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        stall_mem   = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        interr      = 1'b0;
        interr_ack  = 1'b0;
        mem_timeout = 1'b0;
        if (nreset && bus.enable) begin
            unique case (state_q)
                StRun: begin
                    if (bus.i_mem_req && !bus.i_mem_done) begin
                        {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
                        state_d = StMemWait;
                    end else if (bus.i_jump_branch) begin
                        {flush_if, flush_id, flush_ex} = 3'b111;
                        state_d = StRedirect;
                    end else if (bus.i_interr_req) begin
                        {flush_if, flush_id, flush_ex} = 3'b111;
                        interr  = 1'b1;
                        state_d = StIntrWait;
                    end else if (load_use) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                StMemWait: begin
                    // Redirects are ignored here; EX is frozen so the request persists.
                    if (bus.i_mem_done) begin
                        state_d = StRun;
                    end else if (wd_expired) begin
                        {flush_if, flush_id, flush_ex} = 3'b111;
                        mem_timeout = 1'b1;
                        state_d     = StRun;
                    end else begin
                        {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
                    end
                end
                StRedirect: begin
                    flush_if = 1'b1;
                    state_d  = StRun;
                end
                StIntrWait: begin
                    if (bus.i_interr_req) begin
                        interr_ack = 1'b1;
                        stall_if   = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    assign bus.o_stall_if     = stall_if;
    assign bus.o_stall_id     = stall_id;
    assign bus.o_stall_rd_reg = stall_id;
    assign bus.o_stall_wr_reg = stall_mem;
    assign bus.o_stall_ex     = stall_ex;
    assign bus.o_stall_mem    = stall_mem;
    assign bus.o_flush_if     = flush_if;
    assign bus.o_flush_id     = flush_id;
    assign bus.o_flush_ex     = flush_ex;
    assign bus.o_interr       = interr;
    assign bus.o_interr_ack   = interr_ack;
    assign bus.o_mem_timeout  = mem_timeout;

endmodule

// File: tb/tb_riscv_pu_pipe_ctrl.sv
// Directed self-checking bench for riscv_pu_pipe_ctrl (watchdog checks follow
// RISCV_PU_PIPE_CTRL_TIMEOUT_EN).
module tb_riscv_pu_pipe_ctrl;

    // Output vector order: stall if,id,rd_reg,wr_reg,ex,mem | flush if,id,ex | interr,ack,timeout
    localparam logic [11:0] NONE = 12'b000000_000_000;
    localparam logic [11:0] ALLS = 12'b111111_000_000;
    localparam logic [11:0] LU   = 12'b111000_001_000;
    localparam logic [11:0] RD3  = 12'b000000_111_000;
    localparam logic [11:0] RD1  = 12'b000000_100_000;
    localparam logic [11:0] INTR = 12'b000000_111_100;
    localparam logic [11:0] ACK  = 12'b100000_000_010;
    localparam logic [11:0] TOM  = 12'b000000_111_001;

    logic clk;
    logic nreset;
    int   tests_run;
    int   tests_failed;

    riscv_pu_pipe_ctrl_if bus ();

    riscv_pu_pipe_ctrl #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] outs();
        return {bus.o_stall_if, bus.o_stall_id, bus.o_stall_rd_reg, bus.o_stall_wr_reg,
                bus.o_stall_ex, bus.o_stall_mem, bus.o_flush_if, bus.o_flush_id,
                bus.o_flush_ex, bus.o_interr, bus.o_interr_ack, bus.o_mem_timeout};
    endfunction

    task automatic idle();
        bus.enable        = 1'b1;
        bus.i_ex_read     = 1'b0;
        bus.i_ex_rd_addr  = 5'd0;
        bus.i_id_rs1_addr = 5'd0;
        bus.i_id_rs2_addr = 5'd0;
        bus.i_jump_branch = 1'b0;
        bus.i_mem_req     = 1'b0;
        bus.i_mem_done    = 1'b0;
        bus.i_interr_req  = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        idle();
        bus.i_mem_req     = 1'b1;
        bus.i_jump_branch = 1'b1;
        bus.i_interr_req  = 1'b1;
        @(negedge clk);
        tests_run++;
        if (outs() !== NONE) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want %b", outs(), NONE);
        end
        next_cycle();
        idle();
        nreset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (outs() !== NONE) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got %b want %b", outs(), NONE);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        bus.i_ex_read = 1'b1; bus.i_ex_rd_addr = 5'd5; bus.i_id_rs2_addr = 5'd5;
        @(negedge clk);
        tests_run++;
        if (outs() !== LU) begin
            tests_failed++;
            $display("FAIL load_use_rs2: got %b want %b", outs(), LU);
        end
        next_cycle();
        idle();
        @(negedge clk);
        tests_run++;
        if (outs() !== NONE) begin
            tests_failed++;
            $display("FAIL load_use_one_cycle: got %b want %b", outs(), NONE);
        end
        next_cycle();
        bus.i_ex_read = 1'b1; bus.i_ex_rd_addr = 5'd17; bus.i_id_rs1_addr = 5'd17;
        bus.i_id_rs2_addr = 5'd3;
        @(negedge clk);
        tests_run++;
        if (outs() !== LU) begin
            tests_failed++;
            $display("FAIL load_use_rs1: got %b want %b", outs(), LU);
        end
        next_cycle();
        bus.i_ex_rd_addr = 5'd0; bus.i_id_rs1_addr = 5'd0; bus.i_id_rs2_addr = 5'd0;
        @(negedge clk);
        tests_run++;
        if (outs() !== NONE) begin
            tests_failed++;
            $display("FAIL load_use_x0: got %b want %b", outs(), NONE);
        end
        next_cycle();
        bus.i_ex_read = 1'b0; bus.i_ex_rd_addr = 5'd9; bus.i_id_rs1_addr = 5'd9;
        @(negedge clk);
        tests_run++;
        if (outs() !== NONE) begin
            tests_failed++;
            $display("FAIL load_use_no_read: got %b want %b", outs(), NONE);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_mem_wait();
        logic [11:0] exp;
        for (int c = 1; c <= 5; c++) begin
            bus.i_mem_req  = (c <= 4);
            bus.i_mem_done = (c == 4);
            exp = (c <= 3) ? ALLS : NONE;
            @(negedge clk);
            tests_run++;
            if (outs() !== exp) begin
                tests_failed++;
                $display("FAIL mem_wait_c%0d: got %b want %b", c, outs(), exp);
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_redirect();
        logic [11:0] exp;
        for (int c = 0; c < 3; c++) begin
            bus.i_jump_branch = (c == 0);
            exp = (c == 0) ? RD3 : ((c == 1) ? RD1 : NONE);
            @(negedge clk);
            tests_run++;
            if (outs() !== exp) begin
                tests_failed++;
                $display("FAIL redirect_c%0d: got %b want %b", c, outs(), exp);
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_collision();
        logic [11:0] exp;
        for (int c = 0; c < 7; c++) begin
            bus.i_jump_branch = (c == 0);
            bus.i_interr_req  = (c <= 4);
            case (c)
                0:       exp = RD3;
                1:       exp = RD1;
                2:       exp = INTR;
                3, 4:    exp = ACK;
                default: exp = NONE;
            endcase
            @(negedge clk);
            tests_run++;
            if (outs() !== exp) begin
                tests_failed++;
                $display("FAIL collision_c%0d: got %b want %b", c, outs(), exp);
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_priority();
        logic [11:0] exp;
        // Redirect raised with a memory stall, held through MEM_WAIT, taken after.
        for (int c = 0; c < 5; c++) begin
            bus.i_mem_req     = (c <= 2);
            bus.i_mem_done    = (c == 2);
            bus.i_jump_branch = (c <= 3);
            case (c)
                0, 1:    exp = ALLS;
                2:       exp = NONE;
                3:       exp = RD3;
                default: exp = RD1;
            endcase
            @(negedge clk);
            tests_run++;
            if (outs() !== exp) begin
                tests_failed++;
                $display("FAIL prio_mem_redirect_c%0d: got %b want %b", c, outs(), exp);
            end
            next_cycle();
        end
        idle();
        // Interrupt outranks a simultaneous load-use hazard.
        bus.i_interr_req = 1'b1;
        bus.i_ex_read = 1'b1; bus.i_ex_rd_addr = 5'd4; bus.i_id_rs1_addr = 5'd4;
        @(negedge clk);
        tests_run++;
        if (outs() !== INTR) begin
            tests_failed++;
            $display("FAIL prio_intr_over_lu: got %b want %b", outs(), INTR);
        end
        next_cycle();
        idle();
        @(negedge clk);
        tests_run++;
        if (outs() !== NONE) begin
            tests_failed++;
            $display("FAIL prio_intr_release: got %b want %b", outs(), NONE);
        end
        next_cycle();
    endtask

    task automatic test_enable();
        bus.i_mem_req = 1'b1;
        next_cycle();
        bus.enable = 1'b0;
        @(negedge clk);
        tests_run++;
        if (outs() !== NONE) begin
            tests_failed++;
            $display("FAIL enable_low_outputs: got %b want %b", outs(), NONE);
        end
        next_cycle();
        next_cycle();
        bus.enable = 1'b1;
        @(negedge clk);
        tests_run++;
        if (outs() !== ALLS) begin
            tests_failed++;
            $display("FAIL enable_state_held: got %b want %b", outs(), ALLS);
        end
        next_cycle();
        bus.i_mem_done = 1'b1;
        next_cycle();
        idle();
    endtask

    task automatic test_watchdog();
        bus.i_mem_req = 1'b1;
        @(negedge clk);
        tests_run++;
        if (outs() !== ALLS) begin
            tests_failed++;
            $display("FAIL wd_entry: got %b want %b", outs(), ALLS);
        end
        next_cycle();
`ifdef RISCV_PU_PIPE_CTRL_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            tests_run++;
            if (c < 8 && outs() !== ALLS) begin
                tests_failed++;
                $display("FAIL wd_wait_c%0d: got %b want %b", c, outs(), ALLS);
            end else if (c == 8 && (outs() & TOM) !== TOM) begin
                tests_failed++;
                $display("FAIL wd_timeout_pulse: got %b want %b", outs() & TOM, TOM);
            end
            next_cycle();
        end
        idle();
        @(negedge clk);
        tests_run++;
        if (outs() !== NONE) begin
            tests_failed++;
            $display("FAIL wd_after_timeout: got %b want %b", outs(), NONE);
        end
        next_cycle();
`else
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            tests_run++;
            if (outs() !== ALLS) begin
                tests_failed++;
                $display("FAIL wd_disabled_c%0d: got %b want %b", c, outs(), ALLS);
            end
            next_cycle();
        end
        bus.i_mem_done = 1'b1;
        next_cycle();
        idle();
`endif
    endtask

    task automatic test_reset_mid();
        bus.i_mem_req = 1'b1;
        next_cycle();
        #2;
        nreset = 1'b0;
        #1;
        tests_run++;
        if (outs() !== NONE) begin
            tests_failed++;
            $display("FAIL reset_mid_memwait: got %b want %b", outs(), NONE);
        end
        next_cycle();
        idle();
        nreset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (outs() !== NONE) begin
            tests_failed++;
            $display("FAIL reset_mid_release: got %b want %b", outs(), NONE);
        end
        next_cycle();
        // A redirect only flushes from RUN, proving the wait was abandoned.
        bus.i_jump_branch = 1'b1;
        @(negedge clk);
        tests_run++;
        if (outs() !== RD3) begin
            tests_failed++;
            $display("FAIL reset_mid_in_run: got %b want %b", outs(), RD3);
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        idle();
        nreset = 1'b0;
        next_cycle();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_redirect();
        test_collision();
        test_priority();
        test_enable();
        test_watchdog();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/riscv_pu_pipe_ctrl.md
RISCV_PU_PIPE_CTRL -- requirements
Module: riscv_pu_pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, giving the memory-wait watchdog limit in cycles (range 2..65535).
REQ-002 SHALL have port clk, input, 1, the only clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port nreset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port enable, input, 1; when low, all outputs are 0 and the state is held.
REQ-005 SHALL have inputs i_ex_read (1, load in EX), i_ex_rd_addr (5), i_id_rs1_addr (5) and i_id_rs2_addr (5).
REQ-006 SHALL have input i_jump_branch, 1, the taken redirect from EX.
REQ-007 SHALL have inputs i_mem_req (1, MEM stage holds a load/store/descriptor access) and i_mem_done (1, access handshake complete this cycle).
REQ-008 SHALL have input i_interr_req, 1, a level interrupt request.
REQ-009 SHALL have outputs o_stall_if, o_stall_id, o_stall_rd_reg, o_stall_wr_reg, o_stall_ex and o_stall_mem, each 1.
REQ-010 SHALL have outputs o_flush_if, o_flush_id, o_flush_ex, o_interr (pulse), o_interr_ack (level) and o_mem_timeout (pulse), each 1.

Function
REQ-011 SHALL implement FSM states RUN, MEM_WAIT, REDIRECT and INTR_WAIT; outputs are Mealy (state plus current inputs), with no added latency.
REQ-012 In RUN, when i_mem_req=1 and i_mem_done=0, SHALL assert all six stalls in the same cycle and go to MEM_WAIT.
REQ-013 In MEM_WAIT, SHALL assert all stalls while i_mem_done=0; when i_mem_done=1, SHALL deassert all stalls in that cycle and return to RUN.
REQ-014 In RUN with no pending memory access, i_jump_branch=1 SHALL assert o_flush_if, o_flush_id and o_flush_ex for that cycle and enter REDIRECT.
REQ-015 REDIRECT SHALL last exactly 1 cycle, asserting o_flush_if only, then return to RUN.
REQ-016 Load-use hazard = i_ex_read & (i_ex_rd_addr!=0) & (i_ex_rd_addr==i_id_rs1_addr | i_ex_rd_addr==i_id_rs2_addr).
REQ-017 In RUN, a load-use hazard SHALL assert o_stall_if, o_stall_id, o_stall_rd_reg and o_flush_ex for 1 cycle, with no state change.
REQ-018 In RUN with no memory stall and no redirect, i_interr_req=1 SHALL pulse o_interr and flush IF/ID/EX for 1 cycle, then enter INTR_WAIT.
REQ-019 INTR_WAIT SHALL hold o_interr_ack=1 and assert o_stall_if until i_interr_req=0, then return to RUN.
REQ-020 Priority within a cycle SHALL be: memory stall > redirect > interrupt > load-use; any lower-priority event is not consumed and is re-evaluated next cycle.
REQ-021 A redirect arriving while stalled in MEM_WAIT SHALL be ignored; EX is frozen, so the request persists.
REQ-022 o_stall_rd_reg SHALL equal o_stall_id whenever o_stall_id is asserted by this block.
REQ-023 o_stall_wr_reg SHALL equal o_stall_mem.

Reset
REQ-024 While nreset=0, state SHALL be RUN, the watchdog counter 0, and every output 0 regardless of inputs.
REQ-025 Reset asserted mid-MEM_WAIT or mid-INTR_WAIT SHALL abandon the operation; the first cycle after release is RUN.

Configuration
REQ-026 Macro RISCV_PU_PIPE_CTRL_TIMEOUT_EN SHALL control the memory-wait watchdog.
REQ-027 With the macro defined, a 16-bit counter SHALL count cycles in MEM_WAIT. It clears on entry to MEM_WAIT.
REQ-028 With the macro defined, when the counter reaches TIMEOUT_CYCLES-1 without i_mem_done, the block SHALL pulse o_mem_timeout and flush IF/ID/EX for 1 cycle, then go to RUN.
REQ-029 Without the macro, SHALL include no counter, tie o_mem_timeout to 0, and let MEM_WAIT wait indefinitely.

Structure
REQ-030 The FSM state enum type and the default watchdog limit constant SHALL live in riscv_pkg.
REQ-031 Load-use comparison SHALL be a sub-module riscv_pu_hazard_detect (combinational, 1-bit output); the FSM and watchdog stay in riscv_pu_pipe_ctrl.

Verification
REQ-032 Load-use: i_ex_read=1, i_ex_rd_addr=5, i_id_rs2_addr=5 in RUN -> stall_if/id/rd_reg=1 and flush_ex=1 for exactly 1 cycle; same stimulus with rd=0 -> no stall.
REQ-033 Memory wait: i_mem_req=1 for 4 cycles, i_mem_done=1 on the 4th -> all stalls=1 for cycles 1-3 and 0 on cycle 4; state returns to RUN.
REQ-034 Redirect: i_jump_branch=1 for 1 cycle -> flush_if/id/ex=1 in that cycle, then flush_if only in the next cycle, then all flushes 0.
REQ-035 Collision: i_jump_branch=1 and i_interr_req=1 together -> redirect first; o_interr pulses 2 cycles later; o_interr_ack stays high until i_interr_req drops.
REQ-036 Watchdog (macro defined, TIMEOUT_CYCLES=8): i_mem_req=1 with i_mem_done=0 held -> o_mem_timeout pulses on the 8th MEM_WAIT cycle; stalls=0 next cycle. Without the macro, stalls persist past 8 cycles.
REQ-037 Reset: nreset asserted during MEM_WAIT -> all outputs 0 immediately; after release with i_mem_req=0, no stall is asserted.
